// File: rtl/frame_sync_pkg.sv
// Shared types and defaults for the serial frame synchronizer.
package frame_sync_pkg;

  // Synchronizer states: search, confirm over consecutive frames, flywheel.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam int                       DEF_FRAME_LEN = 64;
  localparam int                       DEF_SYNC_LEN  = 16;
  localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC_WORD = 16'hEB90;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_correlator.sv
// Serial shift register with a full-width equality compare against a fixed
// pattern. The newest line bit enters at the LSB, so the pattern reads MSB
// first on the line.
module sync_correlator
  import frame_sync_pkg::*;
#(
  parameter int             LEN     = DEF_SYNC_LEN,
  parameter logic [LEN-1:0] PATTERN = DEF_SYNC_WORD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data,
  output logic match
);

  logic [LEN-1:0] sr;

  // Shift one line bit in per cycle. Clearing to zero means a nonzero
  // pattern can never match on the register contents left by reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[LEN-2:0], data};
    end
  end

  assign match = (sr == PATTERN);

endmodule

// File: rtl/frame_sync.sv
// Receive-side frame synchronizer: hunts for the sync word, confirms it on
// consecutive frame boundaries, then flywheels through isolated misses while
// delivering payload bits with a start-of-frame pulse for the descrambler.
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int                   FRAME_LEN   = DEF_FRAME_LEN,
  parameter int                   SYNC_LEN    = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]  SYNC_WORD   = DEF_SYNC_WORD,
  parameter int                   CONFIRM_CNT = 3,
  parameter int                   LOSS_CNT    = 3
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic data_i,
  output logic data_o,
  output logic data_valid_o,
  output logic sof_o,
  output logic locked_o
);

  localparam int CNT_W  = count_width(FRAME_LEN);
  localparam int HIT_W  = count_width(CONFIRM_CNT);
  localparam int MISS_W = count_width(LOSS_CNT);

  // Last frame position, last payload position, and the counter values at
  // which one more sync hit locks / one more miss drops lock.
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  PAY_LAST   = CNT_W'(FRAME_LEN - SYNC_LEN - 1);
  localparam logic [HIT_W-1:0]  HIT_LAST   = HIT_W'(CONFIRM_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(LOSS_CNT - 1);

  logic match;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [HIT_W-1:0]   hits, hits_n;
  logic [MISS_W-1:0]  miss, miss_n;
  logic               checkpoint;
  logic               payload;
  logic               deliver;

  sync_correlator #(
    .LEN     (SYNC_LEN),
    .PATTERN (SYNC_WORD)
  ) u_corr (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .data  (data_i),
    .match (match)
  );

  // Frame position decode. Position 0 is where the sync word has just fully
  // entered the correlator and data_i carries the first payload bit.
  assign checkpoint = (cnt == '0);
  assign payload    = (cnt <= PAY_LAST);
  assign cnt_inc    = (cnt == FRAME_LAST) ? '0 : cnt + CNT_W'(1);

  // Next-state logic for the hunt/verify/lock machine and its counters.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hits_n  = hits;
    miss_n  = miss;

    unique case (state)
      HUNT: begin
        cnt_n = '0;
        if (match) begin
          // This cycle is position 0 of the candidate frame.
          state_n = VERIFY;
          hits_n  = HIT_W'(1);
          cnt_n   = CNT_W'(1);
        end
      end

      VERIFY: begin
        cnt_n = cnt_inc;
        if (checkpoint) begin
          if (match) begin
            if (hits == HIT_LAST) begin
              state_n = LOCK;
              miss_n  = '0;
            end else begin
              hits_n = hits + HIT_W'(1);
            end
          end else begin
            state_n = HUNT;
            cnt_n   = '0;
          end
        end
      end

      LOCK: begin
        // Matches away from the checkpoint never re-align a locked frame.
        cnt_n = cnt_inc;
        if (checkpoint) begin
          if (match) begin
            miss_n = '0;
          end else if (miss == MISS_LAST) begin
            state_n = HUNT;
            cnt_n   = '0;
          end else begin
            miss_n = miss + MISS_W'(1);
          end
        end
      end

      default: begin
        state_n = HUNT;
        cnt_n   = '0;
      end
    endcase
  end

  // Delivery is judged on the state being entered, so the confirming frame
  // is delivered whole and the frame whose miss drops lock is suppressed.
  assign deliver = (state_n == LOCK) && payload;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= HUNT;
      cnt   <= '0;
      hits  <= '0;
      miss  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hits  <= hits_n;
      miss  <= miss_n;
    end
  end

  // Output registers: one cycle of latency from line bit to payload bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o       <= 1'b0;
      data_valid_o <= 1'b0;
      sof_o        <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      data_o       <= data_i;
      data_valid_o <= deliver;
      sof_o        <= deliver && checkpoint;
      locked_o     <= (state_n == LOCK);
    end
  end

endmodule

// File: tb/tb_frame_sync.sv
// Randomized scoreboard bench for frame_sync. Expected outputs come from a
// behavioural model that finds sync words by scanning the generated line
// history and tracks frame phase relative to the first detected sync.
module tb_frame_sync;

  localparam int          FL      = 64;
  localparam int          SL      = 16;
  localparam int          PL      = FL - SL;
  localparam int          CONFIRM = 3;
  localparam int          LOSS    = 3;
  localparam logic [15:0] SW      = 16'hEB90;

  logic clk = 1'b0;
  logic rstn_i;
  logic data_i;
  logic data_o;
  logic data_valid_o;
  logic sof_o;
  logic locked_o;

  always #5 clk = ~clk;

  frame_sync #(
    .FRAME_LEN   (FL),
    .SYNC_LEN    (SL),
    .SYNC_WORD   (SW),
    .CONFIRM_CNT (CONFIRM),
    .LOSS_CNT    (LOSS)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .sof_o        (sof_o),
    .locked_o     (locked_o)
  );

  typedef struct {
    int   k;
    logic d;
    logic v;
    logic s;
    logic l;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic line[$];

  int checks   = 0;
  int failures = 0;

  // Per-run statistics gathered by the monitor from the DUT outputs.
  int   first_sof;
  int   sof_seen;
  int   valid_win;
  int   win_lo;
  int   win_hi;
  int   lock_drops;
  int   drop_k;
  logic prev_locked;

  // Model state: 0 searching, 1 confirming, 2 locked.
  int m_mode;
  int m_anchor;
  int m_good;
  int m_miss;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // True when the SL line bits just before index k spell the sync word
  // (bits before the start of the run count as zero).
  function automatic bit sync_at(input int k);
    logic [15:0] w;
    int          idx;
    w = '0;
    for (int i = 0; i < SL; i++) begin
      idx = k - SL + i;
      w = {w[14:0], (idx >= 0 && idx < line.size()) ? line[idx] : 1'b0};
    end
    return (w == SW);
  endfunction

  function automatic exp_t model_step(input int k);
    exp_t e;
    bit   s;
    int   pos;
    s   = sync_at(k);
    pos = 0;
    if (m_mode == 0) begin
      if (s) begin
        m_mode   = 1;
        m_anchor = k;
        m_good   = 1;
      end
    end else begin
      pos = (k - m_anchor) % FL;
      if (pos == 0) begin
        if (m_mode == 1) begin
          if (s) begin
            m_good++;
            if (m_good == CONFIRM) begin
              m_mode = 2;
              m_miss = 0;
            end
          end else begin
            m_mode = 0;
          end
        end else begin
          if (s) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == LOSS) m_mode = 0;
          end
        end
      end
    end
    e.k = k;
    e.d = line[k];
    e.l = (m_mode == 2);
    e.v = e.l && (pos < PL);
    e.s = e.v && (pos == 0);
    return e;
  endfunction

  function automatic bit in_mask(input int mask, input int f);
    return ((mask >> f) & 1) != 0;
  endfunction

  // Any sync-word occurrence other than an intended good frame sync
  // (windows touching a frame with deliberately embedded syncs are exempt).
  function automatic bit has_stray(input int bad_mask, input int embed_mask);
    for (int k = 1; k < line.size(); k++) begin
      if (in_mask(embed_mask, (k - 1) / FL)) continue;
      if (k >= SL && in_mask(embed_mask, (k - SL) / FL)) continue;
      if (sync_at(k)) begin
        if (!((k % FL) == SL && !in_mask(bad_mask, k / FL))) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic build(input int nframes, input int bad_mask, input int embed_mask);
    logic [15:0] sw;
    logic [15:0] pat;
    int          base;
    int          off;
    for (int attempt = 0; attempt < 64; attempt++) begin
      line.delete();
      for (int f = 0; f < nframes; f++) begin
        sw = SW;
        if (in_mask(bad_mask, f)) sw[$urandom_range(15, 0)] ^= 1'b1;
        for (int i = SL - 1; i >= 0; i--) line.push_back(sw[i]);
        for (int i = 0; i < PL; i++) line.push_back(1'($urandom_range(1, 0)));
        if (in_mask(embed_mask, f)) begin
          pat  = SW;
          base = f * FL + SL;
          off  = $urandom_range(PL - SL, 0);
          for (int i = 0; i < SL; i++) line[base + off + i] = pat[SL - 1 - i];
        end
      end
      if (!has_stray(bad_mask, embed_mask)) break;
    end
  endtask

  task automatic start_run(input int lo, input int hi);
    sb.delete();
    m_mode      = 0;
    m_anchor    = 0;
    m_good      = 0;
    m_miss      = 0;
    first_sof   = -1;
    sof_seen    = 0;
    valid_win   = 0;
    win_lo      = lo;
    win_hi      = hi;
    lock_drops  = 0;
    drop_k      = -1;
    prev_locked = 1'b0;
  endtask

  // Hold reset for a few cycles, then release with line bit 0 already
  // presented so the first edge after release captures it.
  task automatic apply_reset(input int lo, input int hi);
    rstn_i = 1'b0;
    data_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start_run(lo, hi);
    data_i = line[0];
    rstn_i = 1'b1;
  endtask

  // Stream the whole line; expectation for bit k is queued once the DUT has
  // captured it. A non-negative abort_at asserts reset mid-cycle after that
  // bit and checks the outputs clear without waiting for a clock edge.
  task automatic run_stream(input int abort_at);
    for (int k = 0; k < line.size(); k++) begin
      @(posedge clk);
      #1;
      sb.push_back(model_step(k));
      data_i = (k + 1 < line.size()) ? line[k + 1] : 1'b0;
      if (k == abort_at) begin
        #2;
        check("locked_before_reset", int'(locked_o), 1);
        rstn_i = 1'b0;
        sb.delete();
        #1;
        check("async_reset_outputs", int'({data_o, data_valid_o, sof_o, locked_o}), 0);
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare every registered output cycle against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        if ({data_o, data_valid_o, sof_o, locked_o} !== {mon_e.d, mon_e.v, mon_e.s, mon_e.l}) begin
          failures++;
          $display("FAIL stream k=%0d: got d/v/s/l=%b%b%b%b expected %b%b%b%b",
                   mon_e.k, data_o, data_valid_o, sof_o, locked_o,
                   mon_e.d, mon_e.v, mon_e.s, mon_e.l);
        end
        if (sof_o === 1'b1) begin
          sof_seen++;
          if (first_sof < 0) first_sof = mon_e.k;
        end
        if (data_valid_o === 1'b1 && mon_e.k >= win_lo && mon_e.k < win_hi) valid_win++;
        if (prev_locked === 1'b1 && locked_o === 1'b0) begin
          lock_drops++;
          if (drop_k < 0) drop_k = mon_e.k;
        end
        prev_locked = locked_o;
      end
    end
  end

  initial begin
    rstn_i = 1'b0;
    data_i = 1'b0;

    // Ideal stream: lock on the third sync, 48 of every 64 bits delivered.
    build(8, 0, 0);
    apply_reset(144, 144 + 4 * FL);
    run_stream(-1);
    check("ideal_first_sof", first_sof, 144);
    check("ideal_valid_4_frames", valid_win, 4 * PL);
    check("ideal_lock_drops", lock_drops, 0);

    // Corrupted sync in frame 1: confirmation restarts at frame 2.
    build(8, 32'b10, 0);
    apply_reset(0, 0);
    run_stream(-1);
    check("verify_fail_first_sof", first_sof, 16 + 4 * FL);

    // Two misses then a good sync: flywheel keeps every frame.
    build(7, 32'b11000, 0);
    apply_reset(0, 0);
    run_stream(-1);
    check("flywheel_sof_count", sof_seen, 5);
    check("flywheel_lock_drops", lock_drops, 0);

    // Three misses: lock drops at the third, that frame is not delivered.
    build(8, 32'b111000, 0);
    apply_reset(16 + 5 * FL, 16 + 6 * FL);
    run_stream(-1);
    check("loss_sof_count", sof_seen, 3);
    check("loss_drop_k", drop_k, 16 + 5 * FL);
    check("loss_frame_valid", valid_win, 0);

    // Sync word embedded in payload while locked: ignored.
    build(7, 0, 32'b11000);
    apply_reset(144, 144 + 5 * FL);
    run_stream(-1);
    check("embed_sof_count", sof_seen, 5);
    check("embed_valid_5_frames", valid_win, 5 * PL);

    // Reset mid-payload while locked, then a fresh stream relocks.
    build(5, 0, 0);
    apply_reset(0, 0);
    run_stream(16 + 3 * FL + 20);
    build(5, 0, 0);
    apply_reset(0, 0);
    run_stream(-1);
    check("relock_first_sof", first_sof, 144);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
